count_ctrl: RTL

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/count_ctrl.sv
// Button-driven count controller: three synchronized, debounced buttons steer a
// STOPPED/RUNNING FSM that emits count-enable pulses and a 2-bit mode.
module count_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRESCALE        = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic       en,
  output logic [1:0] mode,
  output logic       running
);

  localparam logic [0:0]  STOPPED = 1'b0;
  localparam logic [0:0]  RUNNING = 1'b1;
  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_RUN  = 1;
  localparam int unsigned B_STEP = 2;

  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      db_q, db_d;
  logic [2:0]      press_q, press_d;
  logic [2:0][7:0] cnt_q, cnt_d;

  logic [0:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] pre_q, pre_d;
  logic        en_q, en_d;

  assign btn_raw = {btn_step, btn_run, btn_mode};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i]   = '0;
      db_d[i]    = db_q[i];
      press_d[i] = 1'b0;
      // press_q marks the cycle after a 0->1 debounced update, so the FSM
      // acts exactly one edge after the debounced state flips
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]    = ~db_q[i];
          press_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    en_d    = 1'b0;

    if (press_q[B_MODE]) begin
      mode_d = mode_q + 2'd1;
    end

    case (state_q)
      STOPPED: begin
        if (press_q[B_RUN]) begin
          state_d = RUNNING;
          pre_d   = '0;
        end else if (press_q[B_STEP]) begin
          en_d = 1'b1;
        end
      end
      default: begin
        // stopping or a mode change restarts the cadence and drops any pulse
        if (press_q[B_RUN]) begin
          state_d = STOPPED;
          pre_d   = '0;
        end else if (press_q[B_MODE]) begin
          pre_d = '0;
        end else if (pre_q == PS_LAST) begin
          pre_d = '0;
          en_d  = 1'b1;
        end else begin
          pre_d = pre_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      press_q <= '0;
      cnt_q   <= '0;
      state_q <= STOPPED;
      mode_q  <= '0;
      pre_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      en_q    <= en_d;
    end
  end

  assign en      = en_q;
  assign mode    = mode_q;
  assign running = (state_q == RUNNING);

endmodule
